// File: rtl/cam_rgb2gray_pipe.sv
// RGB to grayscale converter, PPC lanes per beat, selectable luma weights latched at start of frame.
// Latency 3 clk; one shared enable stalls all stages while out_valid & ~out_ready, and in_ready is that enable.
module cam_rgb2gray_pipe #(
  parameter int DATA_WIDTH = 8,
  parameter int PPC        = 2,
  parameter int COEF_W     = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [1:0]                 cfg_mode,
  input  logic [COEF_W-1:0]          cfg_coef_r,
  input  logic [COEF_W-1:0]          cfg_coef_g,
  input  logic [COEF_W-1:0]          cfg_coef_b,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_sof,
  input  logic                       in_eol,
  input  logic [PPC*DATA_WIDTH-1:0]  in_red,
  input  logic [PPC*DATA_WIDTH-1:0]  in_green,
  input  logic [PPC*DATA_WIDTH-1:0]  in_blue,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_sof,
  output logic                       out_eol,
  output logic [PPC*DATA_WIDTH-1:0]  out_gray
);

  localparam int PW = DATA_WIDTH + COEF_W;
  localparam int SW = PW + 2;
  localparam int GW = SW - COEF_W;

  localparam logic [1:0] MODE_601 = 2'd0;
  localparam logic [1:0] MODE_709 = 2'd1;
  localparam logic [1:0] MODE_EQ  = 2'd2;
  localparam logic [1:0] MODE_CUS = 2'd3;

  // Built-in weights are defined at 8-bit scale and widened for larger COEF_W.
  localparam logic [COEF_W-1:0] W601_R = COEF_W'(77)  << (COEF_W - 8);
  localparam logic [COEF_W-1:0] W601_G = COEF_W'(150) << (COEF_W - 8);
  localparam logic [COEF_W-1:0] W601_B = COEF_W'(29)  << (COEF_W - 8);
  localparam logic [COEF_W-1:0] W709_R = COEF_W'(54)  << (COEF_W - 8);
  localparam logic [COEF_W-1:0] W709_G = COEF_W'(183) << (COEF_W - 8);
  localparam logic [COEF_W-1:0] W709_B = COEF_W'(19)  << (COEF_W - 8);
  localparam logic [COEF_W-1:0] WEQ_R  = COEF_W'(85)  << (COEF_W - 8);
  localparam logic [COEF_W-1:0] WEQ_G  = COEF_W'(86)  << (COEF_W - 8);
  localparam logic [COEF_W-1:0] WEQ_B  = COEF_W'(85)  << (COEF_W - 8);

  localparam logic [SW-1:0] RND  = SW'(1) << (COEF_W - 1);
  localparam logic [GW-1:0] GMAX = {2'b00, {DATA_WIDTH{1'b1}}};

  logic ce;
  logic accept;

  logic [COEF_W-1:0] cfg_w_r, cfg_w_g, cfg_w_b;
  logic [COEF_W-1:0] use_r, use_g, use_b;
  logic [COEF_W-1:0] act_r_q, act_g_q, act_b_q;
  logic [COEF_W-1:0] act_r_d, act_g_d, act_b_d;

  logic                    s1_vld_q, s1_sof_q, s1_eol_q;
  logic                    s1_vld_d, s1_sof_d, s1_eol_d;
  logic [PPC-1:0][PW-1:0]  s1_pr_q, s1_pg_q, s1_pb_q;
  logic [PPC-1:0][PW-1:0]  s1_pr_d, s1_pg_d, s1_pb_d;

  logic                    s2_vld_q, s2_sof_q, s2_eol_q;
  logic [PPC-1:0][SW-1:0]  s2_sum_q, s2_sum_d;

  logic                       out_vld_q, out_sof_q, out_eol_q;
  logic [PPC*DATA_WIDTH-1:0]  out_gray_q, out_gray_d;
  logic [GW-1:0]              g_tmp;

  assign ce       = ~(out_vld_q & ~out_ready);
  assign in_ready = ce;
  assign accept   = in_valid & ce;

  always_comb begin
    cfg_w_r = W601_R;
    cfg_w_g = W601_G;
    cfg_w_b = W601_B;
    case (cfg_mode)
      MODE_709: begin
        cfg_w_r = W709_R;
        cfg_w_g = W709_G;
        cfg_w_b = W709_B;
      end
      MODE_EQ: begin
        cfg_w_r = WEQ_R;
        cfg_w_g = WEQ_G;
        cfg_w_b = WEQ_B;
      end
      MODE_CUS: begin
        cfg_w_r = cfg_coef_r;
        cfg_w_g = cfg_coef_g;
        cfg_w_b = cfg_coef_b;
      end
      default: begin
        cfg_w_r = W601_R;
        cfg_w_g = W601_G;
        cfg_w_b = W601_B;
      end
    endcase
  end

  // The start-of-frame beat itself must already see the freshly selected set.
  always_comb begin
    use_r = in_sof ? cfg_w_r : act_r_q;
    use_g = in_sof ? cfg_w_g : act_g_q;
    use_b = in_sof ? cfg_w_b : act_b_q;
  end

  always_comb begin
    act_r_d = act_r_q;
    act_g_d = act_g_q;
    act_b_d = act_b_q;
    if (accept && in_sof) begin
      act_r_d = cfg_w_r;
      act_g_d = cfg_w_g;
      act_b_d = cfg_w_b;
    end
  end

  always_comb begin
    s1_vld_d = in_valid;
    s1_sof_d = in_valid & in_sof;
    s1_eol_d = in_valid & in_eol;
    s1_pr_d  = '0;
    s1_pg_d  = '0;
    s1_pb_d  = '0;
    for (int i = 0; i < PPC; i++) begin
      s1_pr_d[i] = PW'(in_red[i*DATA_WIDTH +: DATA_WIDTH])   * PW'(use_r);
      s1_pg_d[i] = PW'(in_green[i*DATA_WIDTH +: DATA_WIDTH]) * PW'(use_g);
      s1_pb_d[i] = PW'(in_blue[i*DATA_WIDTH +: DATA_WIDTH])  * PW'(use_b);
    end
  end

  always_comb begin
    s2_sum_d = '0;
    for (int i = 0; i < PPC; i++) begin
      s2_sum_d[i] = SW'(s1_pr_q[i]) + SW'(s1_pg_q[i]) + SW'(s1_pb_q[i]) + RND;
    end
  end

  // Clamp only matters for custom weights summing above unity.
  always_comb begin
    out_gray_d = '0;
    g_tmp      = '0;
    for (int i = 0; i < PPC; i++) begin
      g_tmp = GW'(s2_sum_q[i] >> COEF_W);
      out_gray_d[i*DATA_WIDTH +: DATA_WIDTH] =
        (g_tmp > GMAX) ? {DATA_WIDTH{1'b1}} : g_tmp[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_r_q <= W601_R;
      act_g_q <= W601_G;
      act_b_q <= W601_B;
    end else begin
      act_r_q <= act_r_d;
      act_g_q <= act_g_d;
      act_b_q <= act_b_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q   <= 1'b0;
      s1_sof_q   <= 1'b0;
      s1_eol_q   <= 1'b0;
      s1_pr_q    <= '0;
      s1_pg_q    <= '0;
      s1_pb_q    <= '0;
      s2_vld_q   <= 1'b0;
      s2_sof_q   <= 1'b0;
      s2_eol_q   <= 1'b0;
      s2_sum_q   <= '0;
      out_vld_q  <= 1'b0;
      out_sof_q  <= 1'b0;
      out_eol_q  <= 1'b0;
      out_gray_q <= '0;
    end else if (ce) begin
      s1_vld_q   <= s1_vld_d;
      s1_sof_q   <= s1_sof_d;
      s1_eol_q   <= s1_eol_d;
      s1_pr_q    <= s1_pr_d;
      s1_pg_q    <= s1_pg_d;
      s1_pb_q    <= s1_pb_d;
      s2_vld_q   <= s1_vld_q;
      s2_sof_q   <= s1_sof_q;
      s2_eol_q   <= s1_eol_q;
      s2_sum_q   <= s2_sum_d;
      out_vld_q  <= s2_vld_q;
      out_sof_q  <= s2_sof_q;
      out_eol_q  <= s2_eol_q;
      out_gray_q <= out_gray_d;
    end
  end

  assign out_valid = out_vld_q;
  assign out_sof   = out_sof_q;
  assign out_eol   = out_eol_q;
  assign out_gray  = out_gray_q;

endmodule

// File: tb/tb_cam_rgb2gray_pipe.sv
// Scoreboard bench for cam_rgb2gray_pipe: driver pushes expected beats, monitor pops on each output transfer.
module tb_cam_rgb2gray_pipe;

  localparam int DW  = 8;
  localparam int PPC = 2;
  localparam int CW  = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0]      cfg_mode;
  logic [CW-1:0]   cfg_coef_r, cfg_coef_g, cfg_coef_b;
  logic            in_valid, in_ready, in_sof, in_eol;
  logic [PPC*DW-1:0] in_red, in_green, in_blue;
  logic            out_valid, out_ready, out_sof, out_eol;
  logic [PPC*DW-1:0] out_gray;

  cam_rgb2gray_pipe #(.DATA_WIDTH(DW), .PPC(PPC), .COEF_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_mode(cfg_mode), .cfg_coef_r(cfg_coef_r), .cfg_coef_g(cfg_coef_g), .cfg_coef_b(cfg_coef_b),
    .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof), .in_eol(in_eol),
    .in_red(in_red), .in_green(in_green), .in_blue(in_blue),
    .out_valid(out_valid), .out_ready(out_ready), .out_sof(out_sof), .out_eol(out_eol),
    .out_gray(out_gray)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PPC*DW-1:0] gray;
    logic              sof;
    logic              eol;
    int                acc;
    bit                chk_lat;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  bit   rnd_rdy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [15:0] pk(input logic [7:0] l1, input logic [7:0] l0);
    return {l1, l0};
  endfunction

  function automatic logic [7:0] mdl(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                                     input int wr, input int wg, input int wb);
    int s;
    s = (int'(r) * wr + int'(g) * wg + int'(b) * wb + 128) / 256;
    if (s > 255) s = 255;
    return 8'(s);
  endfunction

  task automatic summary_and_die(input string why);
    $display("FAIL %s: got timeout expected progress", why);
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "aborted");
  endtask

  task automatic send(input logic sof, input logic eol, input logic [15:0] r, input logic [15:0] g,
                      input logic [15:0] b, input logic [15:0] exp_gray, input bit lat);
    int guard;
    in_valid = 1'b1; in_sof = sof; in_eol = eol;
    in_red = r; in_green = g; in_blue = b;
    #1;
    guard = 0;
    while (!in_ready) begin
      @(negedge clk); #1;
      guard++;
      if (guard > 1000) summary_and_die("send_ready_timeout");
    end
    sb.push_back('{exp_gray, sof, eol, cyc, lat});
    @(negedge clk);
    in_valid = 1'b0; in_sof = 1'b0; in_eol = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0; in_sof = 1'b0; in_eol = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input int max_cyc);
    int k;
    k = 0;
    while (sb.size() > 0 && k < max_cyc) begin
      @(negedge clk);
      k++;
    end
    check("drain_queue_empty", sb.size(), 0);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: compares each transferred beat and checks outputs hold across stalls.
  initial begin
    exp_t e;
    logic hold_v;
    logic [PPC*DW-1:0] hold_g;
    logic hold_sof, hold_eol;
    hold_v = 1'b0; hold_g = '0; hold_sof = 1'b0; hold_eol = 1'b0;
    forever begin
      @(negedge clk); #2;
      if (!rst_n) begin
        hold_v = 1'b0;
      end else begin
        if (hold_v) begin
          check("stall_hold_valid", out_valid, 1);
          check("stall_hold_gray", out_gray, hold_g);
          check("stall_hold_sof", out_sof, hold_sof);
          check("stall_hold_eol", out_eol, hold_eol);
        end
        if (out_valid && !out_ready) begin
          check("stall_in_ready", in_ready, 0);
          hold_v = 1'b1; hold_g = out_gray; hold_sof = out_sof; hold_eol = out_eol;
        end else begin
          hold_v = 1'b0;
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_output: got gray %0h expected no beat", out_gray);
          end else begin
            e = sb.pop_front();
            check("gray", out_gray, e.gray);
            check("sof", out_sof, e.sof);
            check("eol", out_eol, e.eol);
            if (e.chk_lat) check("latency", cyc - e.acc, 3);
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    summary_and_die("watchdog");
  end

  initial begin
    logic [7:0] a0, a1, rr0, gg0, bb0, rr1, gg1, bb1;
    rst_n = 1'b1;
    cfg_mode = 2'd0; cfg_coef_r = '0; cfg_coef_g = '0; cfg_coef_b = '0;
    in_valid = 1'b0; in_sof = 1'b0; in_eol = 1'b0;
    in_red = '0; in_green = '0; in_blue = '0;
    #2 rst_n = 1'b0;
    @(negedge clk); #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_out_gray", out_gray, 0);
    check("reset_out_sof", out_sof, 0);
    check("reset_out_eol", out_eol, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    check("reset_in_ready", in_ready, 1);
    @(negedge clk);

    // BT.601: red -> 77, white -> 255
    cfg_mode = 2'd0;
    send(1, 0, pk(255, 255), pk(255, 0), pk(255, 0), pk(255, 77), 1);
    // BT.709 latched at sof; mid-frame mode change ignored until next sof
    cfg_mode = 2'd1;
    send(1, 0, pk(0, 0), pk(0, 255), pk(0, 0), pk(0, 182), 1);
    cfg_mode = 2'd0;
    send(0, 1, pk(0, 0), pk(255, 255), pk(0, 0), pk(182, 182), 1);
    send(1, 0, pk(0, 0), pk(255, 255), pk(0, 0), pk(149, 149), 1);
    // Custom 255/255/255: saturation and small-value rounding
    cfg_mode = 2'd3; cfg_coef_r = 8'd255; cfg_coef_g = 8'd255; cfg_coef_b = 8'd255;
    send(1, 0, pk(1, 255), pk(1, 255), pk(1, 255), pk(3, 255), 1);
    cfg_coef_r = 8'd0; cfg_coef_g = 8'd0; cfg_coef_b = 8'd0;
    send(0, 1, pk(1, 1), pk(1, 1), pk(1, 1), pk(3, 3), 1);
    drain(50);

    // Equal weights: gray of (x,x,x) is x; 64 back-to-back beats
    cfg_mode = 2'd2;
    send(1, 0, pk(100, 100), pk(100, 100), pk(100, 100), pk(100, 100), 1);
    for (int i = 1; i < 64; i++) begin
      a0 = 8'(i * 3);
      a1 = 8'(255 - i);
      send(0, (i % 16) == 15, pk(a1, a0), pk(a1, a0), pk(a1, a0), pk(a1, a0), 1);
    end
    drain(50);

    // 1000 beats, random backpressure and bubbles, custom weights summing above unity
    cfg_mode = 2'd3; cfg_coef_r = 8'd100; cfg_coef_g = 8'd120; cfg_coef_b = 8'd90;
    rnd_rdy = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      rr0 = 8'($urandom); gg0 = 8'($urandom); bb0 = 8'($urandom);
      rr1 = 8'($urandom); gg1 = 8'($urandom); bb1 = 8'($urandom);
      send(i == 0, (i % 20) == 19, pk(rr1, rr0), pk(gg1, gg0), pk(bb1, bb0),
           pk(mdl(rr1, gg1, bb1, 100, 120, 90), mdl(rr0, gg0, bb0, 100, 120, 90)), 0);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    drain(5000);
    rnd_rdy = 1'b0;
    @(negedge clk);

    // Reset with beats in flight: everything discarded, weights back to BT.601
    send(0, 0, pk(10, 10), pk(10, 10), pk(10, 10), pk(0, 0), 0);
    send(0, 0, pk(20, 20), pk(20, 20), pk(20, 20), pk(0, 0), 0);
    in_valid = 1'b0;
    @(negedge clk);
    check("pre_reset_out_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("midrun_reset_out_valid", out_valid, 0);
    check("midrun_reset_out_gray", out_gray, 0);
    check("midrun_reset_out_sof", out_sof, 0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cfg_mode = 2'd1;
    send(0, 1, pk(0, 255), pk(255, 0), pk(0, 0), pk(149, 77), 1);
    drain(50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cam_rgb2gray_pipe.md
# cam_rgb2gray_pipe

Pipelined, parametrised RGB-to-grayscale converter for the camera path, sitting between the demosaic/RGB stage and the grayscale frame buffer or NN preprocessor. Processes PPC pixels per beat with valid/ready backpressure and carries start-of-frame/end-of-line sideband. Adds runtime-selectable luma weights (BT.601, BT.709, equal-weight, custom), round-to-nearest and output saturation. Weight changes are applied only on frame boundaries.

## Interface
- DATA_WIDTH, 8, bits per colour component and per gray output
- PPC, 2, pixels per clock (lanes); lane i occupies bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH]
- COEF_W, 8, coefficient width; weights are unsigned fixed-point, scale 2^COEF_W = 1.0
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- cfg_mode  in  2  0=BT.601, 1=BT.709, 2=equal, 3=custom
- cfg_coef_r / cfg_coef_g / cfg_coef_b  in  COEF_W each  custom weights (mode 3)
- in_valid  in  1  input beat valid
- in_ready  out  1  block accepts beat this cycle
- in_sof  in  1  beat is first of a frame
- in_eol  in  1  beat is last of a line
- in_red / in_green / in_blue  in  PPC*DATA_WIDTH  packed components
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- out_sof / out_eol  out  1  sideband aligned with out_gray
- out_gray  out  PPC*DATA_WIDTH  packed gray result

## Operation
- Built-in weights (COEF_W=8): BT.601 R77 G150 B29; BT.709 R54 G183 B19; equal R85 G86 B85. For COEF_W≠8, built-ins are those values shifted left by (COEF_W-8) (COEF_W ≥ 8 required).
- Active weight set (act_r/g/b) is a register: loaded from cfg_mode/cfg_coef_* on the same edge that accepts a beat with in_sof=1; that beat and all later beats use the new set. Changes to cfg_* at any other time have no effect. Reset value: BT.601.
- Stage 1: per lane, p_c = comp × act_c, width DATA_WIDTH+COEF_W, unsigned.
- Stage 2: s = p_r + p_g + p_b + 2^(COEF_W-1), width DATA_WIDTH+COEF_W+2 (no overflow possible).
- Stage 3: g = s >> COEF_W; if g > 2^DATA_WIDTH-1, output 2^DATA_WIDTH-1, else g. Saturation only reachable with custom weights summing > 2^COEF_W.
- All lanes identical and independent; sof/eol travel in a parallel shift register with valid.
- Pipeline enable ce = ~(out_valid & ~out_ready); all three stages advance together when ce=1. in_ready = ce. A beat is accepted when in_valid & in_ready.
- Bubbles (in_valid=0 while ce=1) propagate as invalid stages; they are not compressed.

## Timing
- Latency: 3 clk from acceptance to out_valid, with no stall.
- Throughput: one beat per clk while out_ready=1.
- in_ready combinational from out_valid/out_ready only; no path from in_valid.
- Stall: while out_valid=1 & out_ready=0, out_gray/out_sof/out_eol/out_valid hold stable and in_ready=0.
- Reset (async assert, sync release on clk): all stage valids 0, out_valid 0, out_gray 0, out_sof 0, out_eol 0, act weights = BT.601, in_ready 1 after reset. Reset mid-frame discards in-flight beats; no partial output.
- in_sof beat accepted during a stall is impossible (in_ready=0); weight load occurs only on actual acceptance.
- Simultaneous out_ready rise and new in_valid: beat accepted same cycle, pipeline advances.

## Test plan
- Mode 0, DATA_WIDTH=8, PPC=2, lane0 RGB=(255,0,0), lane1 (255,255,255), sof=1 -> 3 clk later out_gray lane0=77, lane1=255, out_sof=1.
- Mode 1 at sof, lane0 (0,255,0), lane1 (0,0,0) -> lane0=182, lane1=0; then cfg_mode=0 mid-frame with (0,255,0) -> still 182 until next sof, then 149.
- Mode 3, coefs 255/255/255, RGB=(255,255,255) -> 255 (saturated); RGB=(1,1,1) -> 3.
- Mode 2, RGB=(100,100,100) -> 100 on both lanes; continuous 64-beat stream with out_ready=1 -> 64 outputs on consecutive cycles, eol positions preserved.
- Random out_ready toggling (50%) over 1000 beats -> output sequence matches reference model, no drop/dup, outputs stable during stall.
- Assert rst_n low with 2 beats in flight -> out_valid=0 immediately, out_gray=0, next frame uses BT.601 if sent without sof.
